// File: rtl/cache_line_writeback_pkg.sv
// Shared AXI constants, writeback FSM encodings and cache line geometry.
package cache_line_writeback_pkg;

  localparam int unsigned CACHE_LINE_WIDTH = 6;
  localparam int unsigned TAG_WIDTH        = 20;
  localparam int unsigned OFFSET_WIDTH     = CACHE_LINE_WIDTH - 2;
  localparam int unsigned INDEX_WIDTH      = 32 - TAG_WIDTH - CACHE_LINE_WIDTH;
  localparam int unsigned LINE_WORDS       = 1 << OFFSET_WIDTH;
  localparam int unsigned DATA_WIDTH       = 32;

  localparam logic [3:0] AXI_ID     = 4'b0001;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_ADDR = 2'd1,
    WB_DATA = 2'd2,
    WB_RESP = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]   tag;
    logic [INDEX_WIDTH-1:0] index;
  } wb_line_addr_t;

endpackage

// File: rtl/wb_beat_buffer.sv
// Two-entry FIFO holding prefetched line words until the W channel takes them.
module wb_beat_buffer
  import cache_line_writeback_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_sel;
  logic                  rd_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_sel] <= din;
        wr_sel      <= ~wr_sel;
      end
      if (pop) begin
        rd_sel <= ~rd_sel;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign dout = mem[rd_sel];

endmodule

// File: rtl/cache_line_writeback.sv
// Evicts one dirty cache line as a single AXI3 INCR write burst, prefetching
// words from the line storage read port into a 2-entry beat buffer.
module cache_line_writeback
  import cache_line_writeback_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [TAG_WIDTH-1:0]    wb_tag,
  input  logic [INDEX_WIDTH-1:0]  wb_index,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [OFFSET_WIDTH-1:0] line_roff,
  input  logic [DATA_WIDTH-1:0]   line_rdata,
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [3:0]              wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int unsigned PTR_W = OFFSET_WIDTH + 1;

  wb_state_e             state;
  wb_state_e             state_next;
  wb_line_addr_t         line_addr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  in_flight;
  logic [OFFSET_WIDTH-1:0] beat_cnt;
  logic [OFFSET_WIDTH-1:0] beat_next;
  logic [1:0]            buf_count;
  logic [1:0]            buf_count_next;
  logic [1:0]            occupancy;
  logic [DATA_WIDTH-1:0] buf_dout;
  logic                  accept;
  logic                  aw_hs;
  logic                  push;
  logic                  pop;
  logic                  b_hs;
  logic                  last_beat;
  logic                  issue;
  logic                  busy_d;
  logic                  awvalid_d;
  logic                  wvalid_d;
  logic                  wlast_d;
  logic                  bready_d;
  logic                  done_d;
  logic                  err_d;
  logic                  bid_unused;

  assign accept    = (state == WB_IDLE) && start;
  assign aw_hs     = awvalid && awready;
  assign pop       = wvalid && wready;
  assign b_hs      = bready && bvalid;
  assign push      = in_flight;
  assign last_beat = pop && (beat_cnt == OFFSET_WIDTH'(LINE_WORDS - 1));
  assign occupancy = buf_count + 2'(in_flight);

  // Prefetch keeps buffer+in-flight at most 2, refilling on the pop cycle.
  assign issue = ((state == WB_ADDR) || (state == WB_DATA)) && !rd_ptr[OFFSET_WIDTH] &&
                 ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));

  assign buf_count_next = buf_count + 2'(push) - 2'(pop);
  assign beat_next      = accept ? '0 : (pop ? beat_cnt + OFFSET_WIDTH'(1) : beat_cnt);

  wb_beat_buffer u_beat_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (line_rdata),
    .dout  (buf_dout),
    .count (buf_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      WB_IDLE: if (start)     state_next = WB_ADDR;
      WB_ADDR: if (aw_hs)     state_next = WB_DATA;
      WB_DATA: if (last_beat) state_next = WB_RESP;
      WB_RESP: if (b_hs)      state_next = WB_IDLE;
      default:                state_next = WB_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    busy_d    = 1'b0;
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    wlast_d   = 1'b0;
    bready_d  = 1'b0;
    done_d    = b_hs;
    err_d     = b_hs && (bresp != RESP_OKAY);
    unique case (state_next)
      WB_IDLE: ;
      WB_ADDR: begin
        busy_d    = 1'b1;
        awvalid_d = 1'b1;
      end
      WB_DATA: begin
        busy_d   = 1'b1;
        wvalid_d = (buf_count_next != 2'd0);
        wlast_d  = wvalid_d && (beat_next == OFFSET_WIDTH'(LINE_WORDS - 1));
      end
      WB_RESP: begin
        busy_d   = 1'b1;
        bready_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      wlast   <= 1'b0;
      bready  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      busy    <= busy_d;
      awvalid <= awvalid_d;
      wvalid  <= wvalid_d;
      wlast   <= wlast_d;
      bready  <= bready_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_addr <= '0;
      rd_ptr    <= '0;
      in_flight <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      in_flight <= issue;
      beat_cnt  <= beat_next;
      if (accept) begin
        line_addr <= '{tag: wb_tag, index: wb_index};
        rd_ptr    <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign line_roff  = rd_ptr[OFFSET_WIDTH-1:0];
  assign awid       = AXI_ID;
  assign awaddr     = {line_addr.tag, line_addr.index, CACHE_LINE_WIDTH'(0)};
  assign awlen      = 4'(LINE_WORDS - 1);
  assign awsize     = SIZE_4B;
  assign awburst    = BURST_INCR;
  assign wid        = AXI_ID;
  assign wdata      = buf_dout;
  assign wstrb      = 4'hF;
  assign bid_unused = ^bid;

endmodule

// File: tb/tb_cache_line_writeback.sv
// Directed bench for cache_line_writeback with a synchronous line-storage model.
module tb_cache_line_writeback;
  import cache_line_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [19:0] wb_tag;
  logic [5:0]  wb_index;
  logic        busy, done, err;
  logic [3:0]  line_roff;
  logic [31:0] line_rdata;
  logic [3:0]  awid, awlen, wid, wstrb, bid;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int    checks = 0;
  int    errors = 0;
  string cur_test = "reset";

  always #5 clk = ~clk;

  cache_line_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wb_tag(wb_tag), .wb_index(wb_index),
    .busy(busy), .done(done), .err(err), .line_roff(line_roff), .line_rdata(line_rdata),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  logic [31:0] line_mem [LINE_WORDS];
  always_ff @(posedge clk) line_rdata <= line_mem[line_roff];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %h expected %h", cur_test, tag, obs, exp);
    end
  endtask

  task automatic idle_checks();
    chk("awvalid_0", awvalid, 0);
    chk("wvalid_0", wvalid, 0);
    chk("wlast_0", wlast, 0);
    chk("bready_0", bready, 0);
    chk("busy_0", busy, 0);
    chk("done_0", done, 0);
    chk("err_0", err, 0);
    chk("line_roff_0", line_roff, 0);
    chk("state_idle", dut.state, WB_IDLE);
    chk("buf_empty", dut.u_beat_buf.count, 0);
  endtask

  // Starts a burst in the current cycle; returns at the cycle showing done.
  task automatic run_burst(input string name, input logic [19:0] tag, input logic [5:0] idx,
                           input logic [31:0] exp_addr, input logic [31:0] base,
                           input int aw_delay, input int mode, input logic [1:0] resp,
                           input bit exp_err, input bit mid_start, input int abort_at);
    int beats, cyc, stall, gaps;
    bit hold;
    logic wr;
    logic [31:0] held_data;
    logic held_last;
    cur_test = name;
    for (int k = 0; k < LINE_WORDS; k++) line_mem[k] = base + 32'(k);
    start = 1'b1; wb_tag = tag; wb_index = idx;
    @(negedge clk);
    start = 1'b0;
    chk("busy_up", busy, 1);
    chk("done_low", done, 0);
    chk("err_low", err, 0);
    chk("awvalid_up", awvalid, 1);
    chk("awaddr", awaddr, exp_addr);
    chk("awlen", awlen, 4'hF);
    chk("awsize", awsize, 3'b010);
    chk("awburst", awburst, 2'b01);
    chk("awid", awid, 4'h1);
    chk("wvalid_pre_aw", wvalid, 0);
    for (int i = 0; i < aw_delay; i++) begin
      @(negedge clk);
      chk("awvalid_hold", awvalid, 1);
      chk("awaddr_hold", awaddr, exp_addr);
      chk("wvalid_pre_aw", wvalid, 0);
    end
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    beats = 0; cyc = 0; stall = 0; gaps = 0; hold = 0;
    held_data = '0; held_last = 1'b0;
    while (beats < LINE_WORDS && cyc < 300) begin
      if (abort_at >= 0 && beats == abort_at) begin
        rst_n = 1'b0; wready = 1'b0;
        @(negedge clk);
        idle_checks();
        rst_n = 1'b1;
        return;
      end
      wr = 1'b1;
      if (mode == 1) wr = (cyc % 2 == 0);
      if (mode == 2 && beats == 6 && stall < 10) begin
        wr = 1'b0;
        chk("stall_roff", line_roff, 4'd8);
        if (stall >= 1) chk("stall_buf_full", dut.u_beat_buf.count, 2);
        stall++;
      end
      start = (mid_start && beats == 3 && cyc % 2 == 0);
      wready = wr;
      chk("awvalid_in_data", awvalid, 0);
      if (hold) begin
        chk("hold_wvalid", wvalid, 1);
        chk("hold_wdata", wdata, held_data);
        chk("hold_wlast", wlast, held_last);
      end
      if (wvalid) begin
        chk("wdata", wdata, base + 32'(beats));
        chk("wlast", wlast, (beats == LINE_WORDS - 1));
        chk("wstrb", wstrb, 4'hF);
        chk("wid", wid, 4'h1);
        if (wr) beats++;
      end else begin
        chk("wlast_idle", wlast, 0);
        if (wr && beats > 0) gaps++;
      end
      hold = wvalid && !wr;
      held_data = wdata; held_last = wlast;
      @(negedge clk);
      cyc++;
    end
    wready = 1'b0; start = 1'b0;
    chk("beat_count", beats, LINE_WORDS);
    if (mode != 1) chk("back_to_back_gaps", gaps, 0);
    chk("bready_up", bready, 1);
    chk("wvalid_in_resp", wvalid, 0);
    chk("busy_in_resp", busy, 1);
    chk("done_in_resp", done, 0);
    bvalid = 1'b1; bresp = resp;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    chk("done_pulse", done, 1);
    chk("err", err, exp_err);
    chk("busy_down", busy, 0);
    chk("bready_down", bready, 0);
    chk("state_idle", dut.state, WB_IDLE);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wb_tag = '0; wb_index = '0;
    awready = 1'b0; wready = 1'b0; bid = 4'h1; bresp = 2'b00; bvalid = 1'b0;
    for (int k = 0; k < LINE_WORDS; k++) line_mem[k] = '0;
    repeat (3) @(negedge clk);
    idle_checks();
    rst_n = 1'b1;
    @(negedge clk);

    run_burst("t1_basic", 20'hABCDE, 6'h05, 32'hABCDE140, 32'hC0DE0000, 3, 0, 2'b00, 0, 0, -1);
    @(negedge clk);
    cur_test = "t1_after";
    chk("done_one_cycle", done, 0);

    run_burst("t2_toggle", 20'h12345, 6'h3F, 32'h12345FC0, 32'hC0DE0000, 0, 1, 2'b00, 0, 0, -1);
    @(negedge clk);

    run_burst("t3_stall", 20'hFFFFF, 6'h00, 32'hFFFFF000, 32'h5A5A0000, 1, 2, 2'b00, 0, 0, -1);
    @(negedge clk);

    run_burst("t4_slverr", 20'h00001, 6'h2A, 32'h00001A80, 32'h11110000, 2, 0, 2'b10, 1, 0, -1);
    run_burst("t4_okay", 20'h00001, 6'h2A, 32'h00001A80, 32'h22220000, 0, 0, 2'b00, 0, 0, -1);

    run_burst("t5_midstart", 20'h0BEEF, 6'h11, 32'h0BEEF440, 32'h33330000, 1, 1, 2'b00, 0, 1, -1);
    run_burst("t5_b2b", 20'hFEDCB, 6'h22, 32'hFEDCB880, 32'h44440000, 0, 0, 2'b00, 0, 0, -1);
    @(negedge clk);
    cur_test = "t5_after";
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);

    run_burst("t6_abort", 20'hABCDE, 6'h05, 32'hABCDE140, 32'h55550000, 0, 0, 2'b00, 0, 0, 7);
    @(negedge clk);
    cur_test = "t6_post_reset";
    chk("awvalid_stays_0", awvalid, 0);
    run_burst("t6_rerun", 20'h0CAFE, 6'h01, 32'h0CAFE040, 32'h66660000, 2, 0, 2'b00, 0, 0, -1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
